img_window_renderer: RTL and testbench



---
 rtl/img_render_pkg.sv | 41 ++++
 rtl/pix_delay_line.sv | 38 +++
 rtl/img_window_renderer.sv | 172 +++++++++++++++++
 tb/tb_img_window_renderer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_render_pkg.sv
// Shared types and constants for the image window renderer: display modes,
// the mode resolution table and the black pixel value.
package img_render_pkg;

    typedef enum logic [1:0] {
        MODE_640  = 2'd0,
        MODE_800  = 2'd1,
        MODE_1024 = 2'd2
    } mode_e;

    localparam int H_RES_TBL [3] = '{640, 800, 1024};
    localparam int V_RES_TBL [3] = '{480, 600, 768};

    localparam int BLACK = 0;

    function automatic int h_res(input mode_e m);
        case (m)
            MODE_800:  return H_RES_TBL[1];
            MODE_1024: return H_RES_TBL[2];
            default:   return H_RES_TBL[0];
        endcase
    endfunction

    function automatic int v_res(input mode_e m);
        case (m)
            MODE_800:  return V_RES_TBL[1];
            MODE_1024: return V_RES_TBL[2];
            default:   return V_RES_TBL[0];
        endcase
    endfunction

    // The unused select code 3 falls back to the 640x480 mode.
    function automatic mode_e sel_to_mode(input logic [1:0] s);
        case (s)
            2'd1:    return MODE_800;
            2'd2:    return MODE_1024;
            default: return MODE_640;
        endcase
    endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Generic WIDTH x DEPTH shift register with asynchronous active-low reset
// and a per-bit reset value; used to align sync/DE/window flags with RAM data.
module pix_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_q;
            logic [WIDTH-1:0] stage_d;

            if (gi == 0) begin : g_first
                assign stage_d = d_i;
            end else begin : g_next
                assign stage_d = g_stage[gi-1].stage_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= RST_VAL;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/img_window_renderer.sv
// Centres an IMG_W x IMG_H greyscale image on the active VGA mode, issues RAM
// addresses and emits RGB aligned with delayed sync/DE. Optional red ring: IMG_BORDER_EN.
module img_window_renderer
    import img_render_pkg::*;
#(
    parameter int IMG_W   = 224,
    parameter int IMG_H   = 224,
    parameter int DATA_W  = 8,
    parameter int CH_W    = 2,
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel,
    input  logic              video_on,
    input  logic [10:0]       x_pix,
    input  logic [10:0]       y_pix,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic [CH_W-1:0]   r,
    output logic [CH_W-1:0]   g,
    output logic [CH_W-1:0]   b,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out
);

    if (IMG_W > 640 || IMG_H > 480 || MEM_LAT < 1 || CH_W > DATA_W ||
        (longint'(IMG_W) * longint'(IMG_H)) > (longint'(1) << ADDR_W)) begin : g_cfg_err
        $fatal(1, "img_window_renderer: illegal IMG_W/IMG_H/ADDR_W/MEM_LAT/CH_W");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

`ifdef IMG_BORDER_EN
    localparam int DL_W = 5;
`else
    localparam int DL_W = 4;
`endif

    mode_e              mode_q, mode_d;
    logic               running_q, running_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  address_q, address_d, cur_addr;
    logic               addr_valid_q;
    logic [11:0]        x0, y0, x_end, y_end, xc, yc;
    logic               frame_start, in_win, at_origin;
    logic [DL_W-1:0]    dl_in, dl_out;
    logic               dl_win, dl_ring;
    logic [CH_W-1:0]    pix_val, r_d, g_d, b_d;
    logic [CH_W-1:0]    r_q, g_q, b_q;
    logic               hs_q, vs_q, de_q;
    logic               data_unused;

    assign data_unused = ^data;

    always_comb begin
        xc          = {1'b0, x_pix};
        yc          = {1'b0, y_pix};
        x0          = 12'((h_res(mode_q) - IMG_W) / 2);
        y0          = 12'((v_res(mode_q) - IMG_H) / 2);
        x_end       = x0 + 12'(IMG_W);
        y_end       = y0 + 12'(IMG_H);
        frame_start = (x_pix == 11'd0) && (y_pix == 11'd0);
        at_origin   = (xc == x0) && (yc == y0);
        // Nothing is drawn between reset release and the first frame start.
        in_win      = running_q && video_on && (xc >= x0) && (xc < x_end) &&
                      (yc >= y0) && (yc < y_end);
    end

    // Raster address by counting window pixels, reloaded at the window origin.
    always_comb begin
        mode_d    = frame_start ? sel_to_mode(sel) : mode_q;
        running_d = running_q | frame_start;
        cur_addr  = at_origin ? '0 : cnt_q;
        cnt_d     = cnt_q;
        address_d = '0;
        if (in_win) begin
            address_d = cur_addr;
            cnt_d     = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_640;
            running_q    <= 1'b0;
            cnt_q        <= '0;
            address_q    <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            running_q    <= running_d;
            cnt_q        <= cnt_d;
            address_q    <= address_d;
            addr_valid_q <= in_win;
        end
    end

`ifdef IMG_BORDER_EN
    logic in_ext, ring;
    assign in_ext  = running_q && video_on &&
                     (xc + 12'd1 >= x0) && (xc <= x_end) &&
                     (yc + 12'd1 >= y0) && (yc <= y_end);
    assign ring    = in_ext && !in_win;
    assign dl_in   = {ring, in_win, video_on, hsync_in, vsync_in};
    assign dl_ring = dl_out[4];
`else
    assign dl_in   = {in_win, video_on, hsync_in, vsync_in};
    assign dl_ring = 1'b0;
`endif

    // One cycle short of the full latency: the output register supplies the last.
    pix_delay_line #(
        .WIDTH   (DL_W),
        .DEPTH   (MEM_LAT + 1),
        .RST_VAL (DL_W'(4'b0011))
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dl_in),
        .q_o   (dl_out)
    );

    assign dl_win = dl_out[3];

    always_comb begin
        pix_val = data[DATA_W-1 -: CH_W];
        r_d     = CH_W'(BLACK);
        g_d     = CH_W'(BLACK);
        b_d     = CH_W'(BLACK);
        if (dl_win) begin
            r_d = pix_val;
            g_d = pix_val;
            b_d = pix_val;
        end else if (dl_ring) begin
            r_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            de_q <= 1'b0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            de_q <= dl_out[2];
            hs_q <= dl_out[1];
            vs_q <= dl_out[0];
        end
    end

    assign address    = address_q;
    assign addr_valid = addr_valid_q;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign de_out     = de_q;
    assign hsync_out  = hs_q;
    assign vsync_out  = vs_q;

endmodule

// File: tb/tb_img_window_renderer.sv
// Scoreboard bench for img_window_renderer: a stimulus process pushes expected
// address/pixel results into queues, a negedge monitor pops and compares them.
module tb_img_window_renderer;

    localparam int IMG_W   = 224;
    localparam int IMG_H   = 224;
    localparam int DATA_W  = 8;
    localparam int CH_W    = 2;
    localparam int MEM_LAT = 2;
    localparam int ADDR_W  = 16;
    localparam int L       = MEM_LAT + 2;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int HRES [4] = '{640, 800, 1024, 640};
    localparam int VRES [4] = '{480, 600, 768, 480};
`ifdef IMG_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        sel = 2'd0;
    logic              video_on = 1'b0;
    logic [10:0]       x_pix = 11'd0;
    logic [10:0]       y_pix = 11'd0;
    logic              hsync_in = 1'b1;
    logic              vsync_in = 1'b1;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic [CH_W-1:0]   r, g, b;
    logic              hsync_out, vsync_out, de_out;

    img_window_renderer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W),
        .CH_W(CH_W), .MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .video_on(video_on),
        .x_pix(x_pix), .y_pix(y_pix), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .data(data), .address(address), .addr_valid(addr_valid),
        .r(r), .g(g), .b(b),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
    );

    always #5 clk = ~clk;

    // RAM model: data appears MEM_LAT cycles after the address is presented.
    logic [7:0]        mem [0:65535];
    logic [ADDR_W-1:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= address;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign data = mem[rd_pipe[MEM_LAT-1]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [ADDR_W-1:0] addr; logic vld; } aexp_t;
    typedef struct { int due; logic [1:0] r; logic [1:0] g; logic [1:0] b;
                     logic de; logic hs; logic vs; } pexp_t;
    aexp_t aq [$];
    pexp_t pq [$];

    int  n_run = 0;
    int  n_fail = 0;
    bit  in_reset = 1'b1;

    // Reference model state
    int  mode_m = 0;
    bit  running_m = 1'b0;
    int  cnt_m = 0;

    task automatic model_push(input int c, input int x, input int y, input bit von,
                              input logic [1:0] s, input logic hs, input logic vs);
        int    x0, y0, a;
        bit    win, ext;
        pexp_t pe;
        aexp_t ae;
        logic [7:0] d;
        x0  = (HRES[mode_m] - IMG_W) / 2;
        y0  = (VRES[mode_m] - IMG_H) / 2;
        win = running_m && von && x >= x0 && x < x0 + IMG_W && y >= y0 && y < y0 + IMG_H;
        ext = running_m && von && x >= x0 - 1 && x <= x0 + IMG_W && y >= y0 - 1 && y <= y0 + IMG_H;
        a = 0;
        if (win) begin
            if (x == x0 && y == y0) cnt_m = 0;
            a = cnt_m;
            cnt_m = (cnt_m + 1) % NPIX;
        end
        ae.due = c + 1; ae.addr = ADDR_W'(a); ae.vld = win;
        aq.push_back(ae);
        pe.due = c + L; pe.r = 2'b00; pe.g = 2'b00; pe.b = 2'b00;
        pe.de = von; pe.hs = hs; pe.vs = vs;
        if (win) begin
            d = mem[a];
            pe.r = d[7:6]; pe.g = d[7:6]; pe.b = d[7:6];
        end else if (ext && BORDER) begin
            pe.r = 2'b11;
        end
        pq.push_back(pe);
        if (x == 0 && y == 0) begin
            mode_m    = (s == 2'd3) ? 0 : int'(s);
            running_m = 1'b1;
        end
    endtask

    task automatic step(input int x, input int y, input bit von, input logic [1:0] s);
        @(posedge clk);
        #1;
        x_pix    = 11'(x);
        y_pix    = 11'(y);
        video_on = von;
        sel      = s;
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        model_push(cyc, x, y, von, s, hsync_in, vsync_in);
    endtask

    task automatic chk_reset_outputs(input string tag);
        n_run++;
        if ({r, g, b, de_out, hsync_out, vsync_out, addr_valid} !== {6'b0, 1'b0, 1'b1, 1'b1, 1'b0}
            || address !== '0) begin
            n_fail++;
            $display("FAIL %s: got r=%b g=%b b=%b de=%b hs=%b vs=%b addr=%0d vld=%b, exp all zero with hs=vs=1",
                     tag, r, g, b, de_out, hsync_out, vsync_out, address, addr_valid);
        end
    endtask

    task automatic reset_pulse(input string tag);
        pexp_t pe;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        in_reset  = 1'b1;
        aq.delete();
        pq.delete();
        running_m = 1'b0;
        mode_m    = 0;
        cnt_m     = 0;
        #1;
        chk_reset_outputs(tag);
        video_on = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 1; k < L; k++) begin
            pe.due = cyc + k; pe.r = 2'b00; pe.g = 2'b00; pe.b = 2'b00;
            pe.de = 1'b0; pe.hs = 1'b1; pe.vs = 1'b1;
            pq.push_back(pe);
        end
        model_push(cyc, int'(x_pix), int'(y_pix), video_on, sel, hsync_in, vsync_in);
        in_reset = 1'b0;
    endtask

    task automatic frame(input int s0, input int s1, input bit full);
        int nm, mx0, my0;
        int rows [$];
        int cols [$];
        nm  = (s0 == 3) ? 0 : s0;
        mx0 = (HRES[nm] - IMG_W) / 2;
        my0 = (VRES[nm] - IMG_H) / 2;
        step(0, 0, 1'b1, 2'(s0));
        if (full) begin
            for (int y = 127; y <= 352; y++)
                for (int x = 206; x <= 433; x++)
                    step(x, y, 1'b1, 2'(y >= 300 ? s1 : s0));
        end else begin
            rows = '{127, 128, 129, 351, 352, my0 - 1, my0, my0 + 1,
                     my0 + IMG_H - 1, my0 + IMG_H, int'($urandom_range(1, 700))};
            cols = '{206, 207, 208, 209, 431, 432, 433, mx0 - 1, mx0, mx0 + 1,
                     mx0 + IMG_W - 1, mx0 + IMG_W, int'($urandom_range(1, 1100))};
            rows.sort();
            cols.sort();
            foreach (rows[i])
                foreach (cols[j])
                    step(cols[j], rows[i], $urandom_range(0, 7) != 0,
                         2'(rows[i] >= 300 ? s1 : s0));
        end
    endtask

    // Monitor: compare whatever the DUT presents against the head of each queue.
    always @(negedge clk) begin
        aexp_t ae;
        pexp_t pe;
        if (!in_reset) begin
            while (aq.size() > 0 && aq[0].due <= cyc) begin
                ae = aq.pop_front();
                n_run++;
                if (ae.due != cyc || address !== ae.addr || addr_valid !== ae.vld) begin
                    n_fail++;
                    $display("FAIL addr cyc=%0d due=%0d: got addr=%0d vld=%b, exp addr=%0d vld=%b",
                             cyc, ae.due, address, addr_valid, ae.addr, ae.vld);
                end
            end
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                pe = pq.pop_front();
                n_run++;
                if (pe.due != cyc || r !== pe.r || g !== pe.g || b !== pe.b ||
                    de_out !== pe.de || hsync_out !== pe.hs || vsync_out !== pe.vs) begin
                    n_fail++;
                    $display("FAIL pixel cyc=%0d due=%0d: got rgb=%b/%b/%b de=%b hs=%b vs=%b, exp rgb=%b/%b/%b de=%b hs=%b vs=%b",
                             cyc, pe.due, r, g, b, de_out, hsync_out, vsync_out,
                             pe.r, pe.g, pe.b, pe.de, pe.hs, pe.vs);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[(200 - 128) * IMG_W + (300 - 208)] = 8'hC0;

        reset_pulse("reset_init");

        // Full mode-0 window; sel moves to 1 mid-frame and must not take effect.
        frame(0, 1, 1'b1);
        // Counter wraps to 0 after the last window pixel.
        step(300, 200, 1'b1, 2'd1);
        step(301, 200, 1'b1, 2'd1);

        frame(1, 1, 1'b0);
        frame(2, 2, 1'b0);
        frame(3, 3, 1'b0);
        frame(0, 0, 1'b0);

        step(300, 200, 1'b1, 2'd0);
        reset_pulse("reset_midframe");
        // Window pixels before the next frame start must stay dark.
        step(300, 200, 1'b1, 2'd2);
        step(208, 128, 1'b1, 2'd2);
        step(209, 128, 1'b1, 2'd2);

        for (int f = 0; f < 3; f++) begin
            int s;
            s = int'($urandom_range(0, 3));
            frame(s, s, 1'b0);
        end

        repeat (L + 2) @(posedge clk);
        #6;
        n_run++;
        if (aq.size() != 0 || pq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d addr and %0d pixel items pending, exp 0",
                     aq.size(), pq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
